// File: rtl/cacheline_adapter.sv
// Bridges one cache DFP line request onto the 64-bit bmem bus as a multi-beat burst,
// assembling read beats into a line or serializing a write line into beats.
module cacheline_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [CW-1:0]        r_beat;
    logic [26:0]          r_lineAddr;
    logic [LINE_BITS-1:0] r_line;
    logic                 r_isWrite;
    logic                 w_beatHit;
    logic                 w_unused;

    // Beats tagged with another line (e.g. a stale burst) are dropped.
    assign w_beatHit = bmem_rvalid && (bmem_raddr[31:5] == r_lineAddr);
    assign w_unused  = ^{dfp_addr[4:0], bmem_raddr[4:0]};
    assign bmem_addr = {r_lineAddr, 5'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (dfp_write) begin
                    w_nextState = WR_DATA;
                end else if (dfp_read) begin
                    w_nextState = RD_REQ;
                end
            end
            RD_REQ:  if (bmem_ready) w_nextState = RD_DATA;
            RD_DATA: if (w_beatHit && (r_beat == LAST_BEAT)) w_nextState = RESP;
            WR_DATA: if (bmem_ready && (r_beat == LAST_BEAT)) w_nextState = RESP;
            RESP:    w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The beat index saturates on the last beat and only rewinds from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_lineAddr <= '0;
            r_line     <= '0;
            r_isWrite  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (dfp_write) begin
                        r_lineAddr <= dfp_addr[31:5];
                        r_line     <= dfp_wdata;
                        r_isWrite  <= 1'b1;
                    end else if (dfp_read) begin
                        r_lineAddr <= dfp_addr[31:5];
                        r_isWrite  <= 1'b0;
                    end
                end
                RD_REQ: r_beat <= '0;
                RD_DATA: begin
                    if (w_beatHit) begin
                        r_line[BEAT_BITS*int'(r_beat) +: BEAT_BITS] <= bmem_rdata;
                        if (r_beat != LAST_BEAT) begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (bmem_ready && (r_beat != LAST_BEAT)) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        dfp_rdata  = '0;
        case (r_state)
            RD_REQ: bmem_read = 1'b1;
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_wdata = r_line[BEAT_BITS*int'(r_beat) +: BEAT_BITS];
            end
            RESP: begin
                dfp_resp = 1'b1;
                if (!r_isWrite) begin
                    dfp_rdata = r_line;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: table vectors, directed corner cases
// and randomized transactions checked against a line/beat reference model.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit           isWrite;
        bit           alsoRead;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [31:0]  expAddr;
        logic [255:0] expRdata;
    } vec_t;

    vec_t vecs[5];

    cacheline_adapter #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dfp_resp"}, dfp_resp, 0);
        checkOutput({tag, "_dfp_rdata"}, dfp_rdata, 0);
        checkOutput({tag, "_bmem_read"}, bmem_read, 0);
        checkOutput({tag, "_bmem_write"}, bmem_write, 0);
        checkOutput({tag, "_bmem_addr"}, bmem_addr, 0);
        checkOutput({tag, "_bmem_wdata"}, bmem_wdata, 0);
    endtask

    // Reference model: the burst address is the 32-byte-aligned base of the request.
    function automatic logic [31:0] lineBase(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    // Requester keeps its request high through RESP and the following cycle.
    task automatic finishHandshake();
        step();
        checkOutput("done_resp_low", dfp_resp, 0);
        checkOutput("done_no_read", bmem_read, 0);
        checkOutput("done_no_write", bmem_write, 0);
        step();
        checkOutput("idle_after_done_read", bmem_read, 0);
        checkOutput("idle_after_done_write", bmem_write, 0);
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
    endtask

    task automatic runRead(input logic [31:0] addr, input logic [255:0] line, input logic [255:0] expRdata,
                           input logic [31:0] expAddr, input int reqStall, input int gap, input bit stale);
        logic [31:0] staleAddr;
        staleAddr   = (expAddr == 32'h2000) ? 32'h4000 : 32'h2000;
        dfp_addr    = addr;
        dfp_read    = 1'b1;
        dfp_write   = 1'b0;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        step();
        checkOutput("rd_req_read", bmem_read, 1);
        checkOutput("rd_req_addr", bmem_addr, expAddr);
        for (int i = 0; i < reqStall; i++) begin
            dfp_addr = $urandom;
            step();
            checkOutput("rd_stall_read", bmem_read, 1);
            checkOutput("rd_stall_addr", bmem_addr, expAddr);
        end
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        checkOutput("rd_one_request", bmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap + int'(stale); g++) begin
                if (stale && g == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = staleAddr;
                    bmem_rdata  = {$urandom, $urandom};
                end else begin
                    bmem_rvalid = 1'b0;
                end
                step();
                checkOutput("rd_no_early_resp", dfp_resp, 0);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = expAddr | 32'(k);
            bmem_rdata  = line[k*64 +: 64];
            step();
            bmem_rvalid = 1'b0;
            if (k < 3) checkOutput("rd_no_early_resp", dfp_resp, 0);
        end
        checkOutput("rd_resp", dfp_resp, 1);
        checkOutput("rd_rdata", dfp_rdata, expRdata);
        finishHandshake();
    endtask

    task automatic runWrite(input logic [31:0] addr, input logic [255:0] line, input logic [31:0] expAddr,
                            input logic [15:0] pat, input int patLen, input bit rnd, input bit alsoRead);
        int   accepts  = 0;
        int   wrCycles = 0;
        int   lastAcc  = -10;
        int   respAt   = -1;
        logic r;
        dfp_addr    = addr;
        dfp_wdata   = line;
        dfp_write   = 1'b1;
        dfp_read    = alsoRead;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        step();
        dfp_addr = $urandom;
        for (int c = 0; c < 100; c++) begin
            if (dfp_resp === 1'b1) begin
                respAt = c;
                break;
            end
            checkOutput("wr_no_read", bmem_read, 0);
            r = 1'b0;
            if (bmem_write === 1'b1) begin
                checkOutput("wr_addr", bmem_addr, expAddr);
                r = rnd ? 1'($urandom_range(0, 1)) : ((wrCycles < patLen) ? pat[wrCycles] : 1'b1);
                wrCycles++;
                if (r) begin
                    if (accepts < 4) checkOutput("wr_beat", bmem_wdata, line[accepts*64 +: 64]);
                    accepts++;
                    lastAcc = c;
                end
            end
            bmem_ready = r;
            step();
        end
        bmem_ready = 1'b0;
        checkOutput("wr_resp_seen", respAt >= 0, 1);
        checkOutput("wr_accepts", accepts, 4);
        checkOutput("wr_resp_latency", respAt - lastAcc, 1);
        checkOutput("wr_rdata_zero", dfp_rdata, 0);
        checkOutput("wr_no_beat_in_resp", bmem_write, 0);
        finishHandshake();
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) begin
            runWrite(v.addr, v.line, v.expAddr, 16'hFFFF, 16, 1'b0, v.alsoRead);
        end else begin
            runRead(v.addr, v.line, v.expRdata, v.expAddr, 0, 0, 1'b0);
        end
    endtask

    initial begin
        logic [255:0] rl;
        logic [31:0]  ra;
        bit           isW;

        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        step();
        step();
        checkAllZero("reset");
        rst = 1'b0;
        step();
        checkAllZero("idle_after_reset");

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1047,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    32'h0000_1040,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_0020,
                    256'hDDDD000000000003_CCCC000000000002_BBBB000000000001_AAAA000000000000,
                    32'h8000_0020, 256'h0};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF,
                    256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0F0F0F0FF0F0F0F0,
                    32'hFFFF_FFE0,
                    256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0F0F0F0FF0F0F0F0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_001F,
                    256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888,
                    32'h0000_0000, 256'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_3000,
                    256'hA1A1A1A1A1A1A1A1_B2B2B2B2B2B2B2B2_C3C3C3C3C3C3C3C3_D4D4D4D4D4D4D4D4,
                    32'h0000_3000,
                    256'hA1A1A1A1A1A1A1A1_B2B2B2B2B2B2B2B2_C3C3C3C3C3C3C3C3_D4D4D4D4D4D4D4D4};
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        $display("[TB] read with request backpressure and beat gaps");
        runRead(32'h0000_1047, vecs[0].line, vecs[0].expRdata, 32'h0000_1040, 3, 2, 1'b0);
        $display("[TB] read with stale beats interleaved");
        runRead(32'h0000_1047, vecs[0].line, vecs[0].expRdata, 32'h0000_1040, 0, 1, 1'b1);
        $display("[TB] write with ready pattern 1,0,1,1,0,1");
        runWrite(32'h8000_0020, vecs[1].line, 32'h8000_0020, 16'b101101, 6, 1'b0, 1'b0);
        $display("[TB] back-to-back reads");
        runRead(32'h0000_1047, vecs[0].line, vecs[0].expRdata, 32'h0000_1040, 0, 0, 1'b0);
        runRead(32'h0000_3000, vecs[4].line, vecs[4].expRdata, 32'h0000_3000, 0, 0, 1'b0);

        $display("[TB] reset in the middle of a read burst");
        dfp_addr = 32'h0000_5000; dfp_read = 1'b1;
        step();
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_5000; bmem_rdata = {$urandom, $urandom};
            step();
        end
        bmem_rvalid = 1'b0; dfp_read = 1'b0; rst = 1'b1;
        step();
        checkAllZero("mid_reset");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bmem_rvalid = (k < 2); bmem_raddr = 32'h0000_5000; bmem_rdata = {$urandom, $urandom};
            step();
            checkOutput("post_reset_no_resp", dfp_resp, 0);
            checkOutput("post_reset_no_read", bmem_read, 0);
        end
        bmem_rvalid = 1'b0;
        runRead(32'h0000_5004, vecs[2].line, vecs[2].line, 32'h0000_5000, 1, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            rl  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ra  = $urandom;
            isW = 1'($urandom_range(0, 1));
            if (isW) begin
                runWrite(ra, rl, lineBase(ra), 16'h0, 0, 1'b1, 1'($urandom_range(0, 1)));
            end else begin
                runRead(ra, rl, rl, lineBase(ra), $urandom_range(0, 3), $urandom_range(0, 2),
                        1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder end of the cache DFP interface. It accepts one 256-bit cacheline read or write from a single cache (icache or dcache) and services it as a multi-beat burst on the 64-bit banked-memory (bmem) bus.
- On a read, it assembles the returned beats into a full line and pulses dfp_resp with the line on dfp_rdata.
- On a write, it serializes dfp_wdata into beats and pulses dfp_resp once all beats are accepted.
- One instance sits between each cache's DFP port and the memory arbiter.

Parameters:
- LINE_BITS, 256, cacheline width in bits.
- BEAT_BITS, 64, bmem data width. LINE_BITS/BEAT_BITS must be a power of two; BEATS = LINE_BITS/BEAT_BITS (default 4).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- dfp_addr  in  32  line address. Bits [4:0] are ignored and forced to 0 toward bmem.
- dfp_read  in  1  line read request; the requester holds it high until dfp_resp.
- dfp_write  in  1  line write request; the requester holds it high until dfp_resp.
- dfp_wdata  in  LINE_BITS  write line; must be stable while dfp_write is high.
- dfp_rdata  out  LINE_BITS  assembled read line; valid only while dfp_resp=1.
- dfp_resp  out  1  single-cycle completion pulse.
- bmem_addr  out  32  burst line address, {addr[31:5],5'b0}.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_BITS  write beat data.
- bmem_ready  in  1  memory accepts the current bmem_read or bmem_write this cycle.
- bmem_raddr  in  32  line address tagging the returned read beat.
- bmem_rdata  in  BEAT_BITS  returned read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset:
  - State goes to IDLE; beat counter = 0; latched addr = 0; line buffer = 0.
  - All outputs are 0 (dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata).
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP, DONE.
- IDLE:
  - dfp_write=1: latch addr and wdata, then go to WR_DATA.
  - Else dfp_read=1: latch addr, then go to RD_REQ.
  - Write has priority if both are high; asserting both is a requester error.
  - bmem_rvalid is ignored in IDLE.
- RD_REQ:
  - Drives bmem_read=1 and bmem_addr=latched line address.
  - bmem_ready=1: go to RD_DATA with beat counter=0.
  - bmem_ready=0: hold all bmem outputs stable.
- RD_DATA:
  - Capture a beat only when bmem_rvalid=1 and bmem_raddr[31:5]==latched addr[31:5].
  - Beat k is written to line buffer bits [k*BEAT_BITS +: BEAT_BITS]; the counter then increments.
  - rvalid with a mismatched raddr is dropped and does not advance the counter.
  - When beat BEATS-1 is captured, go to RESP.
  - Gaps between beats are allowed.
- WR_DATA:
  - Drives bmem_write=1, bmem_addr=line address (held for the whole burst), bmem_wdata=beat[counter].
  - The counter advances only in cycles where bmem_ready=1.
  - When the last beat is accepted, go to RESP.
  - The beat index wraps to 0 on entry to the next burst only; it never wraps mid-burst.
- RESP:
  - dfp_resp=1 for exactly one cycle, then go to DONE.
  - dfp_rdata = line buffer on reads; 0 on writes.
- DONE:
  - One-cycle dead state; dfp_read/dfp_write are ignored.
  - This absorbs the requester's still-high request in the cycle after resp.
  - Returns to IDLE.
- Latency:
  - Read: request seen in IDLE at cycle 0; bmem_read at cycle 1; dfp_resp one cycle after the last beat capture.
  - Write: dfp_resp one cycle after the last bmem_ready beat.
- Request changes mid-operation: dfp_addr/dfp_read changes after latching are ignored; the latched transaction always completes.
- Reset mid-burst: return to IDLE immediately; remaining bmem beats are dropped because IDLE ignores rvalid. No dfp_resp is issued for the aborted transaction.
- Output registering: bmem_read, bmem_write, dfp_resp and dfp_rdata are driven from registered state only; no combinational path from dfp_* inputs to bmem_* outputs.

Test Plan:
1. Read, no stalls: dfp_read with addr 0x0000_1047. Expect bmem_read=1 at cycle 1 with bmem_addr=0x0000_1040, bmem_ready=1. Return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with raddr 0x1040 on consecutive cycles. Expect dfp_resp exactly one cycle later, dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, then DONE.
2. Read under backpressure: bmem_ready low for 3 cycles. bmem_read and bmem_addr must hold stable, with exactly one accepted request. Insert 2-cycle gaps between beats. Expect dfp_resp only after the 4th beat.
3. Stale beats: during RD_DATA, inject rvalid with raddr 0x2000. It must be ignored, the counter unchanged, and the final line built only from 0x1040-tagged beats.
4. Write: dfp_write with addr 0x8000_0020 and wdata words W0..W3, with bmem_ready toggling 1,0,1,1,0,1. Expect exactly 4 accepted beats in order W0..W3 and bmem_addr=0x8000_0020 throughout. dfp_resp is one cycle after the 4th accept; dfp_rdata=0.
5. Back-to-back: the requester keeps dfp_read high in the cycle after resp, then issues a new read to 0x3000. Expect no new bmem_read during DONE; the second burst starts from IDLE with the counter reset to 0.
6. Reset mid-burst: assert rst after 2 read beats, then deliver the remaining 2 beats. Expect all outputs 0, no dfp_resp, and a following read completing normally.
